// File: rtl/aes256_key_sched_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes256_key_sched_ctrl
//
// Iterative AES-256 key expansion. A 256-bit cipher key is captured on an
// accepted start. One expansion-step datapath (one shared SubWord of four
// S-boxes) is then reused over 7 iterations. Each iteration has two
// half-steps:
//   STEP_A : RotWord + SubWord + rcon     -> w0..w3 -> rk[2j]
//   STEP_B : SubWord only                 -> w4..w7 -> rk[2j+1]
// All 15 128-bit round keys are kept in a local register file. The round
// cipher reads this file combinationally by index.
//
// Ports
//   clk         in   1    rising-edge clock
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    start a new expansion; ignored while busy
//   key_in      in   256  cipher key, word k = key_in[32k+31:32k]
//                         (AES byte 0 of a word is bits [31:24])
//   busy        out  1    expansion in progress
//   done        out  1    all round keys valid; held until the next accepted start
//   rk_rd_idx   in   4    round-key read index 0..14 (15 reads as zero)
//   rk_rd_data  out  128  rk[rk_rd_idx], packed with the same word order as key_in
// -----------------------------------------------------------------------------
module aes256_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data
);

    localparam int NUM_RK   = 15;
    localparam int NUM_ITER = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP_A = 2'd1,
        S_STEP_B = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef logic [3:0][31:0] quad_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic and the S-box. The S-box is computed as the
    // multiplicative inverse followed by the affine map, instead of a
    // 256-entry table.
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the inverse of x in GF(2^8), and it maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] j);
        logic [7:0] r;
        case (j)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Each new word is the old word XOR the previous new word. The first
    // word of the group uses the SubWord result t instead.
    function automatic quad_t xor_chain(input quad_t w, input logic [31:0] t);
        quad_t r;
        r[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) begin
            r[i] = w[i] ^ r[i-1];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [2:0]         iter_q, iter_d;
    logic [7:0][31:0]   w_q, w_d;
    logic [127:0]       rk_q [NUM_RK];
    logic [127:0]       rk_d [NUM_RK];

    // Shared SubWord. STEP_A rotates w7 first. STEP_B substitutes w3',
    // which was registered by the preceding STEP_A.
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    quad_t       nw_lo;
    quad_t       nw_hi;

    assign sub_in  = (state_q == S_STEP_B) ? w_q[3] : {w_q[7][23:0], w_q[7][31:24]};
    assign sub_out = sub_word(sub_in);
    assign nw_lo   = xor_chain(w_q[3:0], sub_out ^ {rcon(iter_q), 24'h000000});
    assign nw_hi   = xor_chain(w_q[7:4], sub_out);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        w_d     = w_q;
        rk_d    = rk_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_d     = key_in;
                    rk_d[0] = key_in[127:0];
                    rk_d[1] = key_in[255:128];
                    iter_d  = 3'd1;
                    state_d = S_STEP_A;
                end
            end
            S_STEP_A: begin
                w_d[3:0]                = nw_lo;
                rk_d[{iter_q, 1'b0}]    = nw_lo;
                state_d = (iter_q == 3'(NUM_ITER)) ? S_DONE : S_STEP_B;
            end
            S_STEP_B: begin
                w_d[7:4]                = nw_hi;
                rk_d[{iter_q, 1'b1}]    = nw_hi;
                iter_d  = iter_q + 3'd1;
                state_d = S_STEP_A;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers: control and round-key file are reset, working words are not
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= 3'd0;
            for (int i = 0; i < NUM_RK; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            rk_q    <= rk_d;
        end
    end

    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (state_q == S_STEP_A) || (state_q == S_STEP_B);
    assign done = (state_q == S_DONE);

    always_comb begin
        rk_rd_data = '0;
        if (rk_rd_idx != 4'd15) begin
            rk_rd_data = rk_q[rk_rd_idx];
        end
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
`timescale 1ns/1ps
module tb_aes256_key_sched_ctrl;

    typedef logic [14:0][127:0] rk_set_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] FIPS_KEY = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                         32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
    localparam logic [127:0] FIPS_RK2  = {32'h2067fcde, 32'ha51a8b5f, 32'h8e6925af, 32'h9ba35411};
    localparam logic [127:0] FIPS_RK14 = {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1};
    localparam logic [127:0] ZERO_RK2  = {4{32'h62636363}};
    localparam logic [127:0] ZERO_RK3  = {4{32'haafbfbfb}};

    always #5 clk = ~clk;

    aes256_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model: FIPS-197 key expansion ----------------
    logic [7:0] sbox_tab [256];

    // Carry-less product, then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic rk_set_t expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rk_set_t     res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = rc << 1;
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) res[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
        return res;
    endfunction

    // ---------------- reference model: timing and register file ----------------
    // After acceptance at edge T, the model writes round key n+1 at edge T+n
    // for n = 1..13. busy stays high for those 13 edges, and done follows.
    logic         mbusy, mdone;
    int           mcnt;
    logic [127:0] mrk [15];
    rk_set_t      mexp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy <= 1'b0;
            mdone <= 1'b0;
            mcnt  <= 0;
            for (int i = 0; i < 15; i++) mrk[i] <= '0;
        end else if (!mbusy && start) begin
            mexp   <= expand(key_in);
            mrk[0] <= key_in[127:0];
            mrk[1] <= key_in[255:128];
            mbusy  <= 1'b1;
            mdone  <= 1'b0;
            mcnt   <= 0;
        end else if (mbusy) begin
            mrk[mcnt+2] <= mexp[mcnt+2];
            mcnt        <= mcnt + 1;
            if (mcnt == 12) begin
                mbusy <= 1'b0;
                mdone <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("busy", 128'(busy), 128'(mbusy));
        check("done", 128'(done), 128'(mdone));
        check("rk_rd_data", rk_rd_data, (rk_rd_idx == 4'd15) ? 128'h0 : mrk[rk_rd_idx]);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Start one expansion from IDLE/DONE with key k. Key and read index are
    // scrambled every cycle while it runs.
    task automatic run_key(input logic [255:0] k);
        int nb;
        key_in = k;
        start  = 1'b1;
        cyc();
        start     = 1'b0;
        rk_rd_idx = 4'd0;
        #1 check("rk0_after_start", rk_rd_data, k[127:0]);
        rk_rd_idx = 4'd1;
        #1 check("rk1_after_start", rk_rd_data, k[255:128]);
        nb = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (busy) nb++;
            key_in    = rand256();
            rk_rd_idx = 4'($urandom_range(0, 15));
            cyc();
        end
        check("done_reached", 128'(done), 128'(1));
        check("busy_cycles", 128'(nb), 128'(13));
    endtask

    initial begin : main
        rk_set_t e;
        rst_n     = 1'b0;
        start     = 1'b0;
        key_in    = '0;
        rk_rd_idx = 4'd0;
        build_sbox();

        // Literal anchors for the model itself.
        e = expand(FIPS_KEY);
        check("model_fips_rk2", e[2], FIPS_RK2);
        check("model_fips_rk14", e[14], FIPS_RK14);
        e = expand(256'h0);
        check("model_zero_rk2", e[2], ZERO_RK2);
        check("model_zero_rk3", e[3], ZERO_RK3);

        repeat (3) cyc();
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        cyc();

        // FIPS-197 A.3 vector.
        run_key(FIPS_KEY);
        rk_rd_idx = 4'd2;
        #1 check("fips_rk2", rk_rd_data, FIPS_RK2);
        rk_rd_idx = 4'd14;
        #1 check("fips_rk14", rk_rd_data, FIPS_RK14);
        rk_rd_idx = 4'd15;
        #1 check("idx15_done", rk_rd_data, 128'h0);
        cyc();

        // All-zero key.
        run_key(256'h0);
        rk_rd_idx = 4'd2;
        #1 check("zero_rk2", rk_rd_data, ZERO_RK2);
        rk_rd_idx = 4'd3;
        #1 check("zero_rk3", rk_rd_data, ZERO_RK3);
        cyc();

        // start held high with key_in changing every cycle.
        start  = 1'b1;
        key_in = rand256();
        for (int c = 0; c < 45; c++) begin
            cyc();
            key_in    = rand256();
            rk_rd_idx = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        for (int c = 0; c < 40 && !done; c++) cyc();
        check("held_start_done", 128'(done), 128'(1));

        // Reset mid-expansion.
        key_in = rand256();
        start  = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        for (int i = 0; i < 16; i++) begin
            rk_rd_idx = 4'(i);
            #1 check("midrst_rk", rk_rd_data, 128'h0);
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        run_key(FIPS_KEY);
        rk_rd_idx = 4'd2;
        #1 check("post_rst_rk2", rk_rd_data, FIPS_RK2);
        rk_rd_idx = 4'd14;
        #1 check("post_rst_rk14", rk_rd_data, FIPS_RK14);
        cyc();

        // Random keys with random idle gaps.
        for (int n = 0; n < 6; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
                key_in    = rand256();
                rk_rd_idx = 4'($urandom_range(0, 15));
                cyc();
            end
            run_key(rand256());
        end
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
